seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_shift_window.sv | 47 ++++
 rtl/seq_detector_param.sv | 114 +++++++++++
 tb/tb_seq_detector_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the serial pattern detector: FSM states and overlap modes.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_HUNT = 2'd1,
    S_HIT  = 2'd2
  } state_t;

  localparam int OVL_OFF = 0;
  localparam int OVL_ON  = 1;

endpackage

// File: rtl/seq_shift_window.sv
// Serial shift window with saturating fill counter; restart discards the
// collected bits (a simultaneous shift counts as the first new bit).
module seq_shift_window #(
  parameter int SEQ_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic               restart,
  input  logic               din,
  output logic [SEQ_LEN-1:0] window,
  output logic               full,
  output logic               almost_full
);

  localparam int CW = $clog2(SEQ_LEN + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SEQ_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(SEQ_LEN - 1);

  logic [CW-1:0] fill_reg;
  logic [CW-1:0] fill_next;

  always_comb begin
    fill_next = fill_reg;
    if (restart) begin
      fill_next = shift ? CW'(1) : '0;
    end else if (shift && (fill_reg != FULL_CNT)) begin
      fill_next = fill_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window   <= '0;
      fill_reg <= '0;
    end else begin
      fill_reg <= fill_next;
      if (shift) begin
        window <= {window[SEQ_LEN-2:0], din};
      end
    end
  end

  assign full        = (fill_reg == FULL_CNT);
  assign almost_full = (fill_reg == LAST_CNT);

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial sequence detector with loadable pattern.
// Optional saturating match counter enabled by macro SEQ_DET_CNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN     = 4,
  parameter logic [SEQ_LEN-1:0] RST_PATTERN = 4'b1011,
  parameter int                 OVERLAP     = OVL_OFF,
  parameter int                 CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_vld,
  input  logic               din,
  input  logic               pat_we,
  input  logic [SEQ_LEN-1:0] pat_i,
  output logic               match,
  output logic               busy
`ifdef SEQ_DET_CNT_EN
  ,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  state_t             state;
  state_t             state_next;
  logic [SEQ_LEN-1:0] pattern;
  logic [SEQ_LEN-1:0] window;
  logic [SEQ_LEN-1:0] window_next;
  logic               full;
  logic               almost_full;
  logic               shift;
  logic               restart;
  logic               hit;

  // A pattern load discards the bit presented in the same cycle.
  assign shift   = din_vld & ~pat_we;
  assign restart = pat_we | ((state == S_HIT) && (OVERLAP == OVL_OFF));

  seq_shift_window #(
    .SEQ_LEN(SEQ_LEN)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .shift      (shift),
    .restart    (restart),
    .din        (din),
    .window     (window),
    .full       (full),
    .almost_full(almost_full)
  );

  assign window_next = {window[SEQ_LEN-2:0], din};
  assign hit = shift && !restart && (full || almost_full) && (window_next == pattern);

  always_comb begin
    state_next = state;
    if (pat_we) begin
      state_next = S_FILL;
    end else begin
      case (state)
        S_HIT: begin
          if (OVERLAP == OVL_OFF) begin
            state_next = S_FILL;
          end else if (din_vld) begin
            state_next = hit ? S_HIT : S_HUNT;
          end else begin
            state_next = S_HUNT;
          end
        end
        default: begin
          if (din_vld) begin
            if (hit) begin
              state_next = S_HIT;
            end else if (full || almost_full) begin
              state_next = S_HUNT;
            end else begin
              state_next = S_FILL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FILL;
      pattern <= RST_PATTERN;
    end else begin
      state <= state_next;
      if (pat_we) begin
        pattern <= pat_i;
      end
    end
  end

  assign match = (state == S_HIT);
  assign busy  = (state == S_FILL);

`ifdef SEQ_DET_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: one non-overlapping and one overlapping detector share stimulus.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_vld = 1'b0;
  logic       din = 1'b0;
  logic       pat_we = 1'b0;
  logic [3:0] pat_i = 4'b0000;
  logic       cnt_clr = 1'b0;
  logic       match0, busy0, match1, busy1;
  logic [1:0] cnt0, cnt1;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       m0, b0, m1, b1;
    bit         c0;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  seq_detector_param #(.SEQ_LEN(4), .RST_PATTERN(4'b1011), .OVERLAP(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .pat_we(pat_we), .pat_i(pat_i),
    .match(match0), .busy(busy0)
`ifdef SEQ_DET_CNT_EN
    , .cnt_clr(cnt_clr), .match_cnt(cnt0)
`endif
  );

  seq_detector_param #(.SEQ_LEN(4), .RST_PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .pat_we(pat_we), .pat_i(pat_i),
    .match(match1), .busy(busy1)
`ifdef SEQ_DET_CNT_EN
    , .cnt_clr(cnt_clr), .match_cnt(cnt1)
`endif
  );

`ifndef SEQ_DET_CNT_EN
  assign cnt0 = 2'd0;
  assign cnt1 = 2'd0;
`endif

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Monitor: one expected response per driven cycle, checked after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("txn t=%0t m0=%0b b0=%0b m1=%0b b1=%0b cnt1=%0d", $time, match0, busy0, match1, busy1, cnt1);
      if (e.c0) begin
        check("match0", {1'b0, match0}, {1'b0, e.m0});
        check("busy0",  {1'b0, busy0},  {1'b0, e.b0});
      end
      check("match1", {1'b0, match1}, {1'b0, e.m1});
      check("busy1",  {1'b0, busy1},  {1'b0, e.b1});
`ifdef SEQ_DET_CNT_EN
      check("match_cnt1", cnt1, e.cnt);
`endif
    end
  end

  task automatic stepf(input logic v, input logic d, input logic we, input logic [3:0] p,
                       input logic clr, input logic m0, input logic b0, input logic m1,
                       input logic b1, input bit c0, input logic [1:0] cnt);
    exp_t x;
    @(negedge clk);
    din_vld = v; din = d; pat_we = we; pat_i = p; cnt_clr = clr;
    x.m0 = m0; x.b0 = b0; x.m1 = m1; x.b1 = b1; x.c0 = c0; x.cnt = cnt;
    sb.push_back(x);
  endtask

  task automatic st(input logic v, input logic d, input logic m0, input logic b0,
                    input logic m1, input logic b1, input logic [1:0] cnt);
    stepf(v, d, 1'b0, 4'b0000, 1'b0, m0, b0, m1, b1, 1'b1, cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_vld = 1'b0; pat_we = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_match0"}, {1'b0, match0}, 2'd0);
    check({tag, "_busy0"},  {1'b0, busy0},  2'd1);
    check({tag, "_match1"}, {1'b0, match1}, 2'd0);
    check({tag, "_busy1"},  {1'b0, busy1},  2'd1);
`ifdef SEQ_DET_CNT_EN
    check({tag, "_cnt1"}, cnt1, 2'd0);
`endif
  endtask

  // Assert reset between edges and check outputs without waiting for a clock.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1; din_vld = 1'b0; pat_we = 1'b0; cnt_clr = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] bits;
    int hits;
    #2;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    // Basic 1011 detection; afterwards OVERLAP=0 refills, OVERLAP=1 hunts.
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 0, 0, 1, 0, 1, 0);
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 1, 1, 0, 1, 0, 1);
    st(0, 0, 0, 1, 0, 0, 1);

    // 1011011: two hits when overlapping, one otherwise.
    do_reset();
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 0, 0, 1, 0, 1, 0);
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 1, 1, 0, 1, 0, 1);
    st(1, 0, 0, 1, 0, 0, 1);
    st(1, 1, 0, 1, 0, 0, 1);
    st(1, 1, 0, 1, 1, 0, 2);
    st(0, 0, 0, 1, 0, 0, 2);

    // 101, five idle cycles, then 1.
    do_reset();
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 0, 0, 1, 0, 1, 0);
    st(1, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) st(0, 0, 0, 1, 0, 1, 0);
    st(1, 1, 1, 0, 1, 0, 1);
    st(0, 0, 0, 1, 0, 0, 1);

    // Pattern load wins over din; new pattern 0110 then detected.
    do_reset();
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 0, 0, 1, 0, 1, 0);
    st(1, 1, 0, 1, 0, 1, 0);
    stepf(1, 1, 1, 4'b0110, 0, 0, 1, 0, 1, 1'b1, 2'd0);
    st(1, 0, 0, 1, 0, 1, 0);
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 0, 1, 0, 1, 0, 1);

    // Asynchronous reset mid-stream: drops a live match, discards partial bits.
    do_reset();
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 0, 0, 1, 0, 1, 0);
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 1, 1, 0, 1, 0, 1);
    mid_reset("rst_hit");
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 0, 0, 1, 0, 1, 0);
    st(1, 1, 0, 1, 0, 1, 0);
    mid_reset("rst_part");
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 0, 0, 1, 0, 1, 0);
    st(1, 1, 0, 1, 0, 1, 0);
    st(1, 1, 1, 0, 1, 0, 1);

`ifdef SEQ_DET_CNT_EN
    // Five overlapping hits saturate a 2-bit counter; clear beats a hit.
    do_reset();
    bits = 16'b1011011011011011;
    hits = 0;
    for (int k = 1; k <= 16; k++) begin
      logic m;
      m = (k >= 4) && (((k - 4) % 3) == 0);
      if (m) hits++;
      stepf(1, bits[16-k], 0, 4'b0000, 0, 0, 0, m, (k < 4), 1'b0,
            (hits > 3) ? 2'd3 : 2'(hits));
    end
    stepf(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1'b0, 2'd3);
    stepf(1, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 1'b0, 2'd3);
    stepf(1, 1, 0, 4'b0000, 1, 0, 0, 1, 0, 1'b0, 2'd0);
    stepf(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1'b0, 2'd0);
`endif

    @(negedge clk);
    din_vld = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
